// File: rtl/vga_score_render.sv
// Purpose : multi-digit seven-segment score overlay for the 640x480 VGA pixel path,
//           with per-frame score latch, change-blink and an optional colour band.
// Latency : 1 clk from (h_cnt, v_cnt, valid) to colour; upstream delays syncs by 1 clk.
// Backpr. : none; free-running pixel stream, one pixel accepted every clk.
// Ports   : clk/rst (sync, active-high); h_cnt/v_cnt/valid from the VGA controller;
//           score = packed BCD (digit k at [4k+3:4k]); vgaRed/Green/Blue registered
//           colour; blinking high while the post-change blink window runs.
module vga_score_render #(
  parameter int          NUM_DIGITS   = 2,
  parameter int          X0           = 340,
  parameter int          Y0           = 190,
  parameter int          SEG_T        = 10,
  parameter int          SEG_L        = 30,
  parameter int          DIGIT_GAP    = 10,
  parameter logic [11:0] FG           = 12'hfff,
  parameter int          V_LATCH      = 480,
  parameter int          BLINK_FRAMES = 30,
  parameter int          BAND_EN      = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [9:0]                h_cnt,
  input  logic [9:0]                v_cnt,
  input  logic                      valid,
  input  logic [4*NUM_DIGITS-1:0]   score,
  output logic [3:0]                vgaRed,
  output logic [3:0]                vgaGreen,
  output logic [3:0]                vgaBlue,
  output logic                      blinking
);

  localparam int DW   = 2*SEG_T + SEG_L;
  localparam int DH   = 3*SEG_T + 2*SEG_L;
  // A zero-width counter is illegal, so BLINK_FRAMES=0 still gets one bit
  // that is only ever loaded with 0.
  localparam int BC_W = (BLINK_FRAMES > 0) ? $clog2(BLINK_FRAMES + 1) : 1;
  localparam logic [BC_W-1:0] BLINK_INIT = BC_W'(BLINK_FRAMES);

  // Row boundaries shared by every digit, 11 bits so sums cannot wrap.
  localparam logic [10:0] YA0 = 11'(Y0);
  localparam logic [10:0] YF0 = 11'(Y0 + SEG_T);
  localparam logic [10:0] YG0 = 11'(Y0 + SEG_T + SEG_L);
  localparam logic [10:0] YE0 = 11'(Y0 + 2*SEG_T + SEG_L);
  localparam logic [10:0] YD0 = 11'(Y0 + 2*SEG_T + 2*SEG_L);
  localparam logic [10:0] YEND = 11'(Y0 + DH);
  localparam logic [10:0] VL11 = 11'(V_LATCH);

  logic [4*NUM_DIGITS-1:0] shadow;
  logic [BC_W-1:0]         blink_cnt;
  logic [3:0]              phase;
  logic [11:0]             rgb_q;
  logic [11:0]             rgb_d;
  logic [NUM_DIGITS-1:0]   digit_hit;
  logic [10:0]             px;
  logic [10:0]             py;
  logic                    frame_tick;
  logic                    dark;
  logic                    row_a, row_f, row_g, row_e, row_d;

  assign px = {1'b0, h_cnt};
  assign py = {1'b0, v_cnt};
  assign frame_tick = (py == VL11) && (h_cnt == 10'd0);

  assign row_a = (py >= YA0) && (py < YF0);
  assign row_f = (py >= YF0) && (py < YG0);
  assign row_g = (py >= YG0) && (py < YE0);
  assign row_e = (py >= YE0) && (py < YD0);
  assign row_d = (py >= YD0) && (py < YEND);

  // Segment bits {a,b,c,d,e,f,g}; 10-15 decode to nothing.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1111110;
      4'd1:    seg_decode = 7'b0110000;
      4'd2:    seg_decode = 7'b1101101;
      4'd3:    seg_decode = 7'b1111001;
      4'd4:    seg_decode = 7'b0110011;
      4'd5:    seg_decode = 7'b1011011;
      4'd6:    seg_decode = 7'b1011111;
      4'd7:    seg_decode = 7'b1110000;
      4'd8:    seg_decode = 7'b1111111;
      4'd9:    seg_decode = 7'b1111011;
      default: seg_decode = 7'b0000000;
    endcase
  endfunction

  function automatic logic [11:0] band_colour(input logic [3:0] d);
    case (d)
      4'd0:    band_colour = 12'hfff;
      4'd1:    band_colour = 12'h00f;
      4'd2:    band_colour = 12'h0f0;
      4'd3:    band_colour = 12'hf00;
      4'd4:    band_colour = 12'h0ff;
      4'd5:    band_colour = 12'hf0f;
      4'd6:    band_colour = 12'hff0;
      default: band_colour = 12'h000;
    endcase
  endfunction

  // Per-digit hit test against the latched value; digit 0 is rightmost.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    localparam logic [10:0] XL = 11'(X0 + (NUM_DIGITS-1-k)*(DW + DIGIT_GAP));
    localparam logic [10:0] XM = 11'(X0 + (NUM_DIGITS-1-k)*(DW + DIGIT_GAP) + SEG_T);
    localparam logic [10:0] XR = 11'(X0 + (NUM_DIGITS-1-k)*(DW + DIGIT_GAP) + SEG_T + SEG_L);
    localparam logic [10:0] XE = 11'(X0 + (NUM_DIGITS-1-k)*(DW + DIGIT_GAP) + DW);

    logic [6:0] segs;
    logic       col_l, col_m, col_r;

    assign segs  = seg_decode(shadow[4*k +: 4]);
    assign col_l = (px >= XL) && (px < XM);
    assign col_m = (px >= XM) && (px < XR);
    assign col_r = (px >= XR) && (px < XE);

    assign digit_hit[k] = (segs[6] && col_m && row_a) ||
                          (segs[5] && col_r && row_f) ||
                          (segs[4] && col_r && row_e) ||
                          (segs[3] && col_m && row_d) ||
                          (segs[2] && col_l && row_e) ||
                          (segs[1] && col_l && row_f) ||
                          (segs[0] && col_m && row_g);
  end

  // Score is only sampled in vertical blanking so a frame never shows two values.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow    <= '0;
      blink_cnt <= '0;
      phase     <= 4'd0;
    end else if (frame_tick) begin
      shadow <= score;
      if (score != shadow) begin
        blink_cnt <= BLINK_INIT;
        phase     <= 4'd0;
      end else if (blink_cnt != '0) begin
        blink_cnt <= blink_cnt - 1'b1;
        phase     <= phase + 4'd1;
      end
    end
  end

  assign blinking = (blink_cnt != '0);
  // phase[3] gives 8 frames lit then 8 frames dark.
  assign dark     = blinking && phase[3];

  always_comb begin
    rgb_d = 12'h000;
    if (valid) begin
      if ((BAND_EN != 0) && (py < YA0)) begin
        rgb_d = band_colour(shadow[3:0]);
      end else if ((|digit_hit) && !dark) begin
        rgb_d = FG;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q <= 12'h000;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign vgaRed   = rgb_q[11:8];
  assign vgaGreen = rgb_q[7:4];
  assign vgaBlue  = rgb_q[3:0];

endmodule

// File: tb/tb_vga_score_render.sv
// Directed bench for vga_score_render: dut0 has blinking disabled, dut1 uses the
// default 30-frame blink. Frame ticks are produced by driving v_cnt=480,h_cnt=0
// directly rather than sweeping a full raster.
module tb_vga_score_render;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       valid;
  logic [7:0] score;

  logic [3:0] r0, g0, b0, r1, g1, b1;
  logic       bl0, bl1;
  logic [11:0] rgb0, rgb1;

  int errors = 0;
  int checks = 0;

  assign rgb0 = {r0, g0, b0};
  assign rgb1 = {r1, g1, b1};

  always #5 clk = ~clk;

  vga_score_render #(.BLINK_FRAMES(0)) dut0 (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
    .score(score), .vgaRed(r0), .vgaGreen(g0), .vgaBlue(b0), .blinking(bl0)
  );

  vga_score_render dut1 (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
    .score(score), .vgaRed(r1), .vgaGreen(g1), .vgaBlue(b1), .blinking(bl1)
  );

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        vld;
    logic [11:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %03h expected %03h", name, act, exp);
    end
  endtask

  // Present one pixel and sample the registered colour 1 clk later.
  task automatic pix(input logic [9:0] hh, input logic [9:0] vv, input logic vl);
    h_cnt = hh;
    v_cnt = vv;
    valid = vl;
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic [7:0] s);
    score = s;
    h_cnt = 10'd0;
    v_cnt = 10'd480;
    valid = 1'b0;
    @(posedge clk);
    #1;
    h_cnt = 10'd1;
    v_cnt = 10'd0;
  endtask

  vec_t tbl[15];

  initial begin
    int lit;

    // Expected colours with score 8'h18 latched: tens digit at x 340..389,
    // units at x 400..449, rows 190..279.
    tbl[0]  = '{10'd420, 10'd235, 1'b1, 12'hfff}; // units g
    tbl[1]  = '{10'd360, 10'd235, 1'b1, 12'h000}; // tens '1' has no g
    tbl[2]  = '{10'd385, 10'd210, 1'b1, 12'hfff}; // tens b
    tbl[3]  = '{10'd399, 10'd235, 1'b1, 12'h000}; // inter-digit gap
    tbl[4]  = '{10'd420, 10'd235, 1'b0, 12'h000}; // blanked
    tbl[5]  = '{10'd405, 10'd215, 1'b1, 12'hfff}; // units f
    tbl[6]  = '{10'd345, 10'd215, 1'b1, 12'h000}; // tens f off
    tbl[7]  = '{10'd445, 10'd250, 1'b1, 12'hfff}; // units c
    tbl[8]  = '{10'd385, 10'd260, 1'b1, 12'hfff}; // tens c
    tbl[9]  = '{10'd100, 10'd50,  1'b1, 12'h000}; // band, palette 8 -> black
    tbl[10] = '{10'd439, 10'd279, 1'b1, 12'hfff}; // last pixel of units d
    tbl[11] = '{10'd440, 10'd279, 1'b1, 12'h000}; // just right of d
    tbl[12] = '{10'd410, 10'd190, 1'b1, 12'hfff}; // first pixel of units a
    tbl[13] = '{10'd409, 10'd190, 1'b1, 12'h000}; // just left of a
    tbl[14] = '{10'd420, 10'd280, 1'b1, 12'h000}; // just below digit

    // Reset held with active video: everything dark.
    rst = 1'b1;
    score = 8'h18;
    h_cnt = 10'd420;
    v_cnt = 10'd195;
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rst_rgb0_%0d", i), rgb0, 12'h000);
      chk($sformatf("rst_rgb1_%0d", i), rgb1, 12'h000);
      chk($sformatf("rst_blink1_%0d", i), {11'd0, bl1}, 12'h000);
    end
    rst = 1'b0;
    // Shadow still 0 -> units '0' segment a lit one clk after release.
    pix(10'd420, 10'd195, 1'b1);
    chk("first_pix0", rgb0, 12'hfff);
    chk("first_pix1", rgb1, 12'hfff);
    chk("first_blink1", {11'd0, bl1}, 12'h000);

    tick(8'h18);
    chk("blink_on_change", {11'd0, bl1}, 12'h001);
    chk("blink_disabled", {11'd0, bl0}, 12'h000);

    for (int i = 0; i < 15; i++) begin
      pix(tbl[i].h, tbl[i].v, tbl[i].vld);
      chk($sformatf("vec%0d", i), rgb0, tbl[i].exp);
    end

    // Mid-frame score change is invisible until the next tick.
    score = 8'h27;
    pix(10'd10, 10'd300, 1'b1);
    pix(10'd420, 10'd235, 1'b1);
    chk("no_tear", rgb0, 12'hfff);
    tick(8'h27);
    pix(10'd420, 10'd235, 1'b1);
    chk("seven_no_g", rgb0, 12'h000);
    pix(10'd445, 10'd215, 1'b1);
    chk("seven_b", rgb0, 12'hfff);
    // A value present between ticks loses to the value on the tick cycle.
    score = 8'h99;
    pix(10'd10, 10'd300, 1'b1);
    tick(8'h27);
    pix(10'd420, 10'd235, 1'b1);
    chk("tick_value_wins", rgb0, 12'h000);

    // Blink sequence on dut1: 8 frames lit, 8 dark, repeating, for 30 frames.
    tick(8'h19);
    for (int i = 0; i < 30; i++) begin
      pix(10'd405, 10'd215, 1'b1);
      chk($sformatf("blink_frame%0d", i), rgb1, ((i % 16) < 8) ? 12'hfff : 12'h000);
      chk($sformatf("blinking_frame%0d", i), {11'd0, bl1}, 12'h001);
      if (i == 8) chk("noblink_dut_lit", rgb0, 12'hfff);
      tick(8'h19);
    end
    chk("blink_done", {11'd0, bl1}, 12'h000);
    pix(10'd405, 10'd215, 1'b1);
    chk("steady_lit", rgb1, 12'hfff);

    // Band colour from latched units digit; blinking does not touch it.
    tick(8'h13);
    pix(10'd100, 10'd50, 1'b1);
    chk("band3_dut0", rgb0, 12'hf00);
    for (int i = 0; i < 8; i++) tick(8'h13);
    pix(10'd100, 10'd50, 1'b1);
    chk("band3_dark_phase", rgb1, 12'hf00);
    pix(10'd445, 10'd215, 1'b1);
    chk("digit_dark_phase", rgb1, 12'h000);
    tick(8'h19);
    pix(10'd100, 10'd50, 1'b1);
    chk("band9", rgb0, 12'h000);
    tick(8'h15);
    pix(10'd100, 10'd50, 1'b1);
    chk("band5", rgb0, 12'hf0f);
    pix(10'd100, 10'd50, 1'b0);
    chk("band_invalid", rgb0, 12'h000);

    // Units digit 0xA renders blank across its whole cell.
    tick(8'h1A);
    lit = 0;
    for (int y = 190; y < 280; y++) begin
      for (int x = 400; x < 450; x++) begin
        pix(10'(x), 10'(y), 1'b1);
        if (rgb0 != 12'h000) lit++;
      end
    end
    chk("units_A_blank", 12'(lit), 12'h000);
    pix(10'd385, 10'd210, 1'b1);
    chk("tens_1_still_lit", rgb0, 12'hfff);

    // Reset mid-frame clears output and the latched score.
    rst = 1'b1;
    h_cnt = 10'd385;
    v_cnt = 10'd210;
    valid = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_rgb0", rgb0, 12'h000);
    chk("midrst_rgb1", rgb1, 12'h000);
    chk("midrst_blink1", {11'd0, bl1}, 12'h000);
    rst = 1'b0;
    pix(10'd360, 10'd195, 1'b1);
    chk("shadow_cleared_tens_a", rgb0, 12'hfff);
    pix(10'd100, 10'd50, 1'b1);
    chk("shadow_cleared_band", rgb0, 12'hfff);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
